// File: rtl/p4_router_ctrl_initiator_if.sv
// AXI4-Lite bus bundle between the P4 router control initiator and the
// VNP4 s_axi control port. clk is carried so both ends share one clock net.
interface AXI4Lite_int #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input logic clk
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Master (
        input  clk,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport Slave (
        input  clk,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/p4_router_ctrl_initiator.sv
// AXI4-Lite initiator for the VNP4 control port. Turns one valid/ready
// command into one AXI4-Lite read or write, one transaction in flight, and
// returns a single response. A per-transaction watchdog aborts a hung slave.
module p4_router_ctrl_initiator #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    AXI4Lite_int.Master             control
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (DATA_WIDTH != 32) begin : g_dw_chk
            $error("p4_router_ctrl_initiator: DATA_WIDTH must be 32");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_to_chk
            $error("p4_router_ctrl_initiator: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R, RSP} state_t;

    typedef struct packed {
        logic awvalid;
        logic wvalid;
        logic bready;
        logic arvalid;
        logic rready;
    } bus_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            resp;
        logic                  timeout;
    } rsp_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    bus_t                    bus_q, bus_d;
    rsp_t                    rsp_q, rsp_d;
    logic                    rdy_q, rdy_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    at_lim;
    logic                    abort;

    // Every output comes straight from a flop; reset kills all valids at once.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bus_q   <= '0;
            rsp_q   <= '0;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            rsp_q   <= rsp_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Next state and next registered outputs; a completing handshake is
    // checked before the watchdog so it wins on the limit cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        rsp_d   = rsp_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        abort   = 1'b0;
        at_lim  = (cnt_q == CNT_MAX);

        // Saturate so a transfer that moves WR->WR_B on the limit cycle
        // times out on the following cycle instead of wrapping.
        if (state_q inside {WR, WR_B, RD, RD_R})
            cnt_d = at_lim ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid && rdy_q) begin
                    cnt_d  = '0;
                    addr_d = cmd_addr;
                    if (cmd_write) begin
                        wdata_d       = cmd_wdata;
                        wstrb_d       = cmd_wstrb;
                        bus_d.awvalid = 1'b1;
                        bus_d.wvalid  = 1'b1;
                        state_d       = WR;
                    end else begin
                        bus_d.arvalid = 1'b1;
                        state_d       = RD;
                    end
                end
            end
            WR: begin
                if (bus_q.awvalid && control.awready) bus_d.awvalid = 1'b0;
                if (bus_q.wvalid && control.wready)   bus_d.wvalid  = 1'b0;
                if (!bus_d.awvalid && !bus_d.wvalid) begin
                    bus_d.bready = 1'b1;
                    state_d      = WR_B;
                end else if (at_lim) begin
                    abort = 1'b1;
                end
            end
            WR_B: begin
                if (control.bvalid) begin
                    rsp_d        = '{valid: 1'b1, rdata: '0, resp: control.bresp, timeout: 1'b0};
                    bus_d.bready = 1'b0;
                    state_d      = RSP;
                end else if (at_lim) begin
                    abort = 1'b1;
                end
            end
            RD: begin
                if (control.arready) begin
                    bus_d.arvalid = 1'b0;
                    bus_d.rready  = 1'b1;
                    state_d       = RD_R;
                end else if (at_lim) begin
                    abort = 1'b1;
                end
            end
            RD_R: begin
                if (control.rvalid) begin
                    rsp_d        = '{valid: 1'b1, rdata: control.rdata, resp: control.rresp, timeout: 1'b0};
                    bus_d.rready = 1'b0;
                    state_d      = RSP;
                end else if (at_lim) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon the hung transfer: drop every valid/ready, report SLVERR.
        if (abort) begin
            bus_d   = '0;
            rsp_d   = '{valid: 1'b1, rdata: '0, resp: 2'b10, timeout: 1'b1};
            state_d = RSP;
        end
    end

    assign rdy_d = (state_d == IDLE);

    assign cmd_ready   = rdy_q;
    assign rsp_valid   = rsp_q.valid;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_resp    = rsp_q.resp;
    assign rsp_timeout = rsp_q.timeout;

    assign control.awaddr  = addr_q;
    assign control.awprot  = 3'b000;
    assign control.awvalid = bus_q.awvalid;
    assign control.wdata   = wdata_q;
    assign control.wstrb   = wstrb_q;
    assign control.wvalid  = bus_q.wvalid;
    assign control.bready  = bus_q.bready;
    assign control.araddr  = addr_q;
    assign control.arprot  = 3'b000;
    assign control.arvalid = bus_q.arvalid;
    assign control.rready  = bus_q.rready;
endmodule

// File: tb/tb_p4_router_ctrl_initiator.sv
// Directed bench for p4_router_ctrl_initiator: table of commands against a
// configurable AXI4-Lite slave, plus busy-hold and mid-transfer reset cases.
module tb_p4_router_ctrl_initiator;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;

    AXI4Lite_int #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ctl (.clk(clk));

    p4_router_ctrl_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .control(ctl)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
    bit         cfg_hang = 0, cfg_junk = 0;
    logic [1:0] cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int aw_c, w_c, ar_c, b_c, r_c;

    // Readies/responses change on the falling edge, away from DUT sampling.
    always @(negedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ctl.awready <= 1'b0; ctl.wready <= 1'b0; ctl.arready <= 1'b0;
            ctl.bvalid  <= 1'b0; ctl.bresp  <= 2'b00;
            ctl.rvalid  <= 1'b0; ctl.rresp  <= 2'b00; ctl.rdata <= '0;
            aw_c <= 0; w_c <= 0; ar_c <= 0; b_c <= 0; r_c <= 0;
        end else begin
            if (ctl.awvalid) begin ctl.awready <= (aw_c >= cfg_aw_dly); aw_c <= aw_c + 1; end
            else begin ctl.awready <= 1'b0; aw_c <= 0; end
            if (ctl.wvalid) begin ctl.wready <= (w_c >= cfg_w_dly); w_c <= w_c + 1; end
            else begin ctl.wready <= 1'b0; w_c <= 0; end
            if (ctl.arvalid) begin ctl.arready <= (ar_c >= cfg_ar_dly); ar_c <= ar_c + 1; end
            else begin ctl.arready <= 1'b0; ar_c <= 0; end
            if (ctl.bready) begin
                ctl.bvalid <= !cfg_hang && (b_c >= cfg_b_dly); ctl.bresp <= cfg_resp; b_c <= b_c + 1;
            end else begin
                ctl.bvalid <= cfg_junk; ctl.bresp <= 2'b11; b_c <= 0;
            end
            if (ctl.rready) begin
                ctl.rvalid <= !cfg_hang && (r_c >= cfg_r_dly); ctl.rresp <= cfg_resp;
                ctl.rdata <= cfg_rdata; r_c <= r_c + 1;
            end else begin
                ctl.rvalid <= cfg_junk; ctl.rresp <= 2'b11; ctl.rdata <= 32'hBAD0BAD0; r_c <= 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int aw_hs = 0, w_hs = 0, ar_hs = 0, ar_wait = 0, stab_err = 0, acc_cnt = 0;
    logic [AW-1:0] m_awaddr, m_araddr, p_awaddr, p_araddr;
    logic [DW-1:0] m_wdata, p_wdata;
    logic [3:0]    m_wstrb, p_wstrb;
    bit p_aw = 0, p_w = 0, p_ar = 0;

    // Counts handshakes and flags any valid that drops or changes payload early.
    always @(posedge clk) begin
        if (!aresetn) begin
            p_aw <= 0; p_w <= 0; p_ar <= 0;
        end else begin
            if (ctl.awvalid && ctl.awready) begin aw_hs <= aw_hs + 1; m_awaddr <= ctl.awaddr; end
            if (ctl.wvalid && ctl.wready) begin w_hs <= w_hs + 1; m_wdata <= ctl.wdata; m_wstrb <= ctl.wstrb; end
            if (ctl.arvalid && ctl.arready) begin ar_hs <= ar_hs + 1; m_araddr <= ctl.araddr; end
            if (ctl.arvalid && !ctl.arready) ar_wait <= ar_wait + 1;
            if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
            if ((p_aw && (!ctl.awvalid || ctl.awaddr !== p_awaddr)) ||
                (p_w  && (!ctl.wvalid  || ctl.wdata !== p_wdata || ctl.wstrb !== p_wstrb)) ||
                (p_ar && (!ctl.arvalid || ctl.araddr !== p_araddr)))
                stab_err <= stab_err + 1;
            p_aw <= ctl.awvalid && !ctl.awready; p_awaddr <= ctl.awaddr;
            p_w  <= ctl.wvalid && !ctl.wready;   p_wdata <= ctl.wdata; p_wstrb <= ctl.wstrb;
            p_ar <= ctl.arvalid && !ctl.arready; p_araddr <= ctl.araddr;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
        bit          hang, junk;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        int          hold;
        logic [31:0] e_rdata;
        logic [1:0]  e_resp;
        bit          e_to;
        int          e_lat;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [14:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                                int awd, int wd, int ard, int bd, int rd, bit hang, bit junk,
                                logic [1:0] sresp, logic [31:0] srdata, int hold,
                                logic [31:0] e_rdata, logic [1:0] e_resp, bit e_to, int e_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_dly = awd; v.w_dly = wd; v.ar_dly = ard; v.b_dly = bd; v.r_dly = rd;
        v.hang = hang; v.junk = junk; v.sresp = sresp; v.srdata = srdata; v.hold = hold;
        v.e_rdata = e_rdata; v.e_resp = e_resp; v.e_to = e_to; v.e_lat = e_lat;
        return v;
    endfunction

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic set_cfg(input vec_t v);
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_ar_dly = v.ar_dly;
        cfg_b_dly = v.b_dly; cfg_r_dly = v.r_dly; cfg_hang = v.hang; cfg_junk = v.junk;
        cfg_resp = v.sresp; cfg_rdata = v.srdata;
    endtask

    // Issue one command, measure latency (cycle offset from the accept cycle),
    // check the response, hold it for v.hold cycles, then consume it.
    task automatic run(input int i, input vec_t v);
        int n, k, bad, aw0, w0, ar0, arw0, st0;
        logic [36:0] snap;
        set_cfg(v);
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; arw0 = ar_wait; st0 = stab_err;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        check($sformatf("v%0d cmd_ready", i), cmd_ready, 1'b1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
        check($sformatf("v%0d latency", i), k + 1, v.e_lat);
        check($sformatf("v%0d rsp_rdata", i), rsp_rdata, v.e_rdata);
        check($sformatf("v%0d rsp_resp", i), rsp_resp, v.e_resp);
        check($sformatf("v%0d rsp_timeout", i), rsp_timeout, v.e_to);
        check($sformatf("v%0d bus idle", i),
              {ctl.awvalid, ctl.wvalid, ctl.bready, ctl.arvalid, ctl.rready, cmd_ready}, 6'b0);
        snap = {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready};
        bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready} !== snap) bad++;
        end
        if (v.hold > 0) check($sformatf("v%0d hold stable", i), bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        check($sformatf("v%0d after rsp", i), {rsp_valid, cmd_ready}, 2'b01);
        if (v.wr) begin
            check($sformatf("v%0d aw/w/ar hs", i), {aw_hs - aw0, w_hs - w0, ar_hs - ar0}, {32'd1, 32'd1, 32'd0});
            check($sformatf("v%0d awaddr", i), m_awaddr, v.addr);
            check($sformatf("v%0d wdata/wstrb", i), {m_wdata, m_wstrb}, {v.wdata, v.wstrb});
        end else begin
            check($sformatf("v%0d aw/w/ar hs", i), {aw_hs - aw0, w_hs - w0, ar_hs - ar0}, {32'd0, 32'd0, 32'd1});
            check($sformatf("v%0d araddr", i), m_araddr, v.addr);
            check($sformatf("v%0d ar wait", i), ar_wait - arw0, v.ar_dly);
        end
        check($sformatf("v%0d payload stable", i), stab_err - st0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, a0;
        //               wr addr      wdata         strb aw w ar b  r  hang junk resp rdata         hold e_rdata       e_resp to lat
        vecs[0] = mk(1, 15'h0040, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0,        0, 32'h0,        2'd0, 0, 3);
        vecs[1] = mk(0, 15'h1FFC, 32'h0,        4'h0, 0, 0, 5, 0, 0, 0, 0, 2'd0, 32'h12345678, 0, 32'h12345678, 2'd0, 0, 8);
        vecs[2] = mk(1, 15'h0100, 32'hA5A50F0F, 4'h3, 3, 0, 0, 2, 0, 0, 0, 2'd1, 32'h0,        0, 32'h0,        2'd1, 0, 8);
        vecs[3] = mk(1, 15'h7FFC, 32'h11112222, 4'hF, 0, 0, 0, 0, 0, 1, 0, 2'd0, 32'h0,        0, 32'h0,        2'd2, 1, 17);
        vecs[4] = mk(0, 15'h0008, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 32'hCAFEF00D, 4, 32'hCAFEF00D, 2'd2, 0, 3);
        vecs[5] = mk(0, 15'h0010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 1, 1, 2'd0, 32'h55555555, 0, 32'h0,        2'd2, 1, 17);
        vecs[6] = mk(1, 15'h0044, 32'h00000001, 4'h1, 0, 2, 0, 0, 0, 0, 1, 2'd0, 32'h0,        0, 32'h0,        2'd0, 0, 5);
        vecs[7] = mk(0, 15'h1000, 32'h0,        4'h0, 0, 0, 0, 0, 3, 0, 0, 2'd0, 32'h89ABCDEF, 1, 32'h89ABCDEF, 2'd0, 0, 6);
        vecs[8] = mk(1, 15'h0200, 32'hFFFF0000, 4'hC, 0, 0, 0, 14, 0, 0, 0, 2'd3, 32'h0,       0, 32'h0,        2'd3, 0, 17);
        vecs[9] = mk(1, 15'h0204, 32'h00000000, 4'hF, 0, 0, 0, 15, 0, 0, 0, 2'd0, 32'h0,       0, 32'h0,        2'd2, 1, 17);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset cmd_ready", cmd_ready, 1'b0);
        check("reset rsp", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout}, 36'h0);
        check("reset bus", {ctl.awvalid, ctl.wvalid, ctl.bready, ctl.arvalid, ctl.rready}, 5'b0);
        @(negedge clk) aresetn = 1'b1;
        @(posedge clk); #1;
        check("release cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < NV; i++) run(i, vecs[i]);

        // Command held valid while busy: accepted once, then again after one IDLE cycle.
        set_cfg(mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2'd0, 32'h0F0F0F0F, 0, 0, 0, 0, 0));
        a0 = acc_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 15'h0020;
        @(posedge clk); #1;
        cmd_write = 1'b1; cmd_addr = 15'h0024; cmd_wdata = 32'h00000077; cmd_wstrb = 4'hF;
        k = 0;
        while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("busy rsp_rdata", rsp_rdata, 32'h0F0F0F0F);
        check("busy not accepted", acc_cnt - a0, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        check("idle gap cmd_ready", cmd_ready, 1'b1);
        check("idle gap no accept", acc_cnt - a0, 1);
        @(posedge clk); #1;
        check("b2b accepted", {acc_cnt - a0, 31'd0, cmd_ready}, {32'd2, 32'd0});
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("b2b write rsp", {rsp_valid, rsp_resp, rsp_timeout}, 4'b1000);
        check("b2b awaddr", m_awaddr, 15'h0024);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;

        // Reset while awvalid is stuck high.
        set_cfg(mk(1, 0, 0, 0, 1000, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 15'h0300; cmd_wdata = 32'h12121212;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset awvalid", ctl.awvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check("async reset drop", {ctl.awvalid, ctl.wvalid, ctl.bready, rsp_valid, cmd_ready}, 5'b0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("post-reset cmd_ready", cmd_ready, 1'b1);
        run(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
